// File: rtl/dffram_arb2.sv
// Two-port round-robin arbiter in front of a single-port DFFRAM (registered read, 1-cycle latency).
// Define DFFRAM_ARB_FIXED_PRIO_EN to make port 0 always win simultaneous requests.
module dffram_arb2 #(
  parameter  int WSIZE   = 4,
  localparam int A_WIDTH = 8 + $clog2(WSIZE)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               P0_REQ,
  input  logic [3:0]         P0_WE,
  input  logic [A_WIDTH-1:0] P0_A,
  input  logic [31:0]        P0_Di,
  output logic               P0_ACK,
  output logic [31:0]        P0_Do,
  input  logic               P1_REQ,
  input  logic [3:0]         P1_WE,
  input  logic [A_WIDTH-1:0] P1_A,
  input  logic [31:0]        P1_Di,
  output logic               P1_ACK,
  output logic [31:0]        P1_Do,
  output logic               RAM_EN,
  output logic [3:0]         RAM_WE,
  output logic [A_WIDTH-1:0] RAM_A,
  output logic [31:0]        RAM_Di,
  input  logic [31:0]        RAM_Do
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SERVE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0] state_q, state_d;
  logic       gnt_q, gnt_d;
  logic       winner;

`ifdef DFFRAM_ARB_FIXED_PRIO_EN
  // Port 1 wins only when port 0 is silent.
  always_comb begin
    winner = ~P0_REQ;
  end
`else
  logic last_q, last_d;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    if (P0_REQ && P1_REQ) begin
      winner = ~last_q;
    end else begin
      winner = P1_REQ;
    end
  end

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && (P0_REQ || P1_REQ)) begin
      last_d = winner;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (P0_REQ || P1_REQ) begin
          gnt_d   = winner;
          state_d = SERVE;
        end
      end
      SERVE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
    end
  end

  // Outputs decode directly from state so reset zeroes them in the same cycle.
  always_comb begin
    RAM_EN = 1'b0;
    RAM_WE = 4'h0;
    RAM_A  = '0;
    RAM_Di = 32'h0;
    P0_ACK = 1'b0;
    P1_ACK = 1'b0;
    P0_Do  = 32'h0;
    P1_Do  = 32'h0;
    if (state_q == SERVE) begin
      RAM_EN = 1'b1;
      RAM_WE = gnt_q ? P1_WE : P0_WE;
      RAM_A  = gnt_q ? P1_A  : P0_A;
      RAM_Di = gnt_q ? P1_Di : P0_Di;
    end else if (state_q == DONE) begin
      if (gnt_q) begin
        P1_ACK = 1'b1;
        P1_Do  = RAM_Do;
      end else begin
        P0_ACK = 1'b1;
        P0_Do  = RAM_Do;
      end
    end
  end

endmodule

// File: tb/tb_dffram_arb2.sv
// Directed bench for dffram_arb2 with a behavioural registered-read RAM model.
module tb_dffram_arb2;

  localparam int AW = 10;

  logic          CLK = 1'b0;
  logic          RST;
  logic          P0_REQ, P1_REQ;
  logic [3:0]    P0_WE, P1_WE;
  logic [AW-1:0] P0_A, P1_A;
  logic [31:0]   P0_Di, P1_Di;
  logic          P0_ACK, P1_ACK;
  logic [31:0]   P0_Do, P1_Do;
  logic          RAM_EN;
  logic [3:0]    RAM_WE;
  logic [AW-1:0] RAM_A;
  logic [31:0]   RAM_Di;
  logic [31:0]   RAM_Do;

  int n_chk  = 0;
  int n_fail = 0;

  dffram_arb2 #(.WSIZE(4)) dut (
    .CLK(CLK), .RST(RST),
    .P0_REQ(P0_REQ), .P0_WE(P0_WE), .P0_A(P0_A), .P0_Di(P0_Di), .P0_ACK(P0_ACK), .P0_Do(P0_Do),
    .P1_REQ(P1_REQ), .P1_WE(P1_WE), .P1_A(P1_A), .P1_Di(P1_Di), .P1_ACK(P1_ACK), .P1_Do(P1_Do),
    .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_A(RAM_A), .RAM_Di(RAM_Di), .RAM_Do(RAM_Do)
  );

  always #5 CLK = ~CLK;

  // RAM model: read-before-write, output zero after a disabled cycle.
  logic [31:0] mem [0:1023] = '{default: 32'h0};
  logic [31:0] ram_do_r = 32'h0;
  assign RAM_Do = ram_do_r;

  always @(posedge CLK) begin
    if (RAM_EN) begin
      ram_do_r <= mem[RAM_A];
      for (int b = 0; b < 4; b++) begin
        if (RAM_WE[b]) mem[RAM_A][8*b +: 8] <= RAM_Di[8*b +: 8];
      end
    end else begin
      ram_do_r <= 32'h0;
    end
  end

  typedef struct {
    logic        port;
    logic [3:0]  we;
    logic [9:0]  a;
    logic [31:0] di;
    logic [31:0] exp_do;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_ports();
    P0_REQ = 0; P0_WE = 4'hF; P0_A = 10'h155; P0_Di = 32'hBAD0BAD0;
    P1_REQ = 0; P1_WE = 4'hF; P1_A = 10'h2AA; P1_Di = 32'hBAD1BAD1;
  endtask

  task automatic check_quiet(input string name);
    chk({name, "_ram_en"}, {31'h0, RAM_EN}, 32'h0);
    chk({name, "_ram_bus"}, {18'h0, RAM_WE, RAM_A} | RAM_Di, 32'h0);
    chk({name, "_acks"}, {30'h0, P1_ACK, P0_ACK}, 32'h0);
    chk({name, "_dos"}, P0_Do | P1_Do, 32'h0);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    if (v.port) begin
      P1_REQ = 1; P1_WE = v.we; P1_A = v.a; P1_Di = v.di;
    end else begin
      P0_REQ = 1; P0_WE = v.we; P0_A = v.a; P0_Di = v.di;
    end
    tick();
    chk($sformatf("v%0d_serve_en", i), {31'h0, RAM_EN}, 32'h1);
    chk($sformatf("v%0d_serve_we", i), {28'h0, RAM_WE}, {28'h0, v.we});
    chk($sformatf("v%0d_serve_a", i), {22'h0, RAM_A}, {22'h0, v.a});
    chk($sformatf("v%0d_serve_di", i), RAM_Di, v.di);
    chk($sformatf("v%0d_serve_acks", i), {30'h0, P1_ACK, P0_ACK}, 32'h0);
    tick();
    chk($sformatf("v%0d_done_en", i), {31'h0, RAM_EN}, 32'h0);
    chk($sformatf("v%0d_done_acks", i), {30'h0, P1_ACK, P0_ACK}, v.port ? 32'h2 : 32'h1);
    chk($sformatf("v%0d_done_do", i), v.port ? P1_Do : P0_Do, v.exp_do);
    chk($sformatf("v%0d_done_other_do", i), v.port ? P0_Do : P1_Do, 32'h0);
    idle_ports();
    tick();
    check_quiet($sformatf("v%0d_idle", i));
    $display("vec %0d port %0d we %b a %h di %h do_exp %h", i, v.port, v.we, v.a, v.di, v.exp_do);
  endtask

  initial begin
    logic exp_p;
    vecs[0] = '{1'b0, 4'b1111, 10'h010, 32'hDEADBEEF, 32'h00000000};
    vecs[1] = '{1'b0, 4'b0000, 10'h010, 32'h00000000, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 4'b1111, 10'h020, 32'h11223344, 32'h00000000};
    vecs[3] = '{1'b1, 4'b0010, 10'h020, 32'h0000AB00, 32'h11223344};
    vecs[4] = '{1'b1, 4'b0000, 10'h020, 32'h00000000, 32'h1122AB44};
    vecs[5] = '{1'b0, 4'b0001, 10'h3FF, 32'h000000AA, 32'h00000000};
    vecs[6] = '{1'b1, 4'b0000, 10'h3FF, 32'h00000000, 32'h000000AA};
    vecs[7] = '{1'b0, 4'b1000, 10'h3FF, 32'h55000000, 32'h000000AA};
    vecs[8] = '{1'b0, 4'b0000, 10'h3FF, 32'h00000000, 32'h550000AA};

    RST = 1;
    idle_ports();
    P0_REQ = 1; P1_REQ = 1;
    tick(); tick();
    check_quiet("reset_hold");
    idle_ports();
    RST = 0;
    tick();
    check_quiet("after_reset");
    $display("reset released");

    for (int i = 0; i < 9; i++) run_vec(i);

    // Continuous tie after a fresh reset.
    RST = 1; tick(); RST = 0;
    P0_REQ = 1; P0_WE = 0; P0_A = 10'h010; P0_Di = 0;
    P1_REQ = 1; P1_WE = 0; P1_A = 10'h020; P1_Di = 0;
    for (int k = 0; k < 4; k++) begin
`ifdef DFFRAM_ARB_FIXED_PRIO_EN
      exp_p = 1'b0;
`else
      exp_p = k[0];
`endif
      tick();
      chk($sformatf("tie%0d_ram_a", k), {22'h0, RAM_A}, exp_p ? 32'h020 : 32'h010);
      tick();
      chk($sformatf("tie%0d_acks", k), {30'h0, P1_ACK, P0_ACK}, exp_p ? 32'h2 : 32'h1);
      chk($sformatf("tie%0d_do", k), exp_p ? P1_Do : P0_Do, exp_p ? 32'h1122AB44 : 32'hDEADBEEF);
      tick();
      chk($sformatf("tie%0d_gap", k), {30'h0, P1_ACK, P0_ACK}, 32'h0);
      $display("tie access %0d expected port %0d", k, exp_p);
    end
    idle_ports();
    tick();
    check_quiet("tie_end");

    // Reset during SERVE of a P1 read.
    P1_REQ = 1; P1_WE = 0; P1_A = 10'h020;
    tick();
    chk("rst_pre_en", {31'h0, RAM_EN}, 32'h1);
    RST = 1;
    #1;
    check_quiet("rst_in_serve");
    tick();
    RST = 0;
    idle_ports();
    for (int k = 0; k < 3; k++) begin
      tick();
      check_quiet($sformatf("rst_after%0d", k));
    end
    P0_REQ = 1; P0_WE = 0; P0_A = 10'h010;
    P1_REQ = 1; P1_WE = 0; P1_A = 10'h020;
    tick();
    chk("rst_tie_ram_a", {22'h0, RAM_A}, 32'h010);
    tick();
    chk("rst_tie_acks", {30'h0, P1_ACK, P0_ACK}, 32'h1);
    chk("rst_tie_do", P0_Do, 32'hDEADBEEF);
    idle_ports();
    tick();
    $display("reset-in-serve sequence done");

    // P1 pulses REQ only while P0 is being served: must be dropped.
    P0_REQ = 1; P0_WE = 0; P0_A = 10'h3FF;
    tick();
    P1_REQ = 1; P1_WE = 0; P1_A = 10'h020;
    chk("pulse_serve_a", {22'h0, RAM_A}, 32'h3FF);
    tick();
    idle_ports();
    chk("pulse_done_acks", {30'h0, P1_ACK, P0_ACK}, 32'h1);
    chk("pulse_done_do", P0_Do, 32'h550000AA);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_quiet($sformatf("pulse_after%0d", k));
    end
    $display("dropped-request sequence done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dffram_arb2.md
DFFRAM_ARB2 -- requirements
Module: dffram_arb2

Interface
REQ-001 The block SHALL have parameter WSIZE, default 4, giving RAM size in 256-word banks; local A_WIDTH = 8+clog2(WSIZE).
REQ-002 The block SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-003 The block SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have ports Pn_REQ  input  1  access request from requester n, n in {0,1}.
REQ-005 The block SHALL have ports Pn_WE  input  4  byte write enables from requester n; 0000 means read.
REQ-006 The block SHALL have ports Pn_A  input  A_WIDTH  word address from requester n.
REQ-007 The block SHALL have ports Pn_Di  input  32  write data from requester n.
REQ-008 The block SHALL have ports Pn_ACK  output  1  one-cycle completion pulse to requester n.
REQ-009 The block SHALL have ports Pn_Do  output  32  read data to requester n, valid only while Pn_ACK=1.
REQ-010 The block SHALL have port RAM_EN  output  1  RAM enable.
REQ-011 The block SHALL have port RAM_WE  output  4  RAM byte write enables.
REQ-012 The block SHALL have port RAM_A  output  A_WIDTH  RAM address.
REQ-013 The block SHALL have port RAM_Di  output  32  RAM write data.
REQ-014 The block SHALL have port RAM_Do  input  32  RAM read data; registered, one-cycle latency, zero when previous-cycle RAM_EN=0.

Function
REQ-015 The block SHALL implement FSM states IDLE, SERVE, DONE plus a 1-bit grant register GNT and 1-bit last-winner register LAST.
REQ-016 IDLE: if any Pn_REQ=1 at a clock edge, the winner is loaded into GNT, LAST<=winner, and state goes to SERVE; otherwise stays IDLE.
REQ-017 SERVE SHALL last exactly one cycle: RAM_EN=1, RAM_WE/RAM_A/RAM_Di = P[GNT]_WE/_A/_Di; next state DONE.
REQ-018 DONE SHALL last exactly one cycle: P[GNT]_ACK=1, P[GNT]_Do=RAM_Do; next state IDLE.
REQ-019 Outside SERVE, RAM_EN, RAM_WE, RAM_A, RAM_Di SHALL all be zero.
REQ-020 Outside its DONE cycle, Pn_ACK SHALL be 0 and Pn_Do SHALL be 32'h0; at most one Pn_ACK high per cycle.
REQ-021 Latency: Pn_REQ sampled high in IDLE at edge k -> RAM_EN high in cycle k..k+1 -> Pn_ACK high in cycle k+1..k+2; one access per 3 cycles max.
REQ-022 Requester SHALL hold Pn_WE/_A/_Di stable from REQ assertion through ACK; REQ still high in the cycle after ACK is a new request.
REQ-023 Writes SHALL still return ACK; Pn_Do on a write returns the pre-write word content.
REQ-024 Simultaneous requests: winner is the port not equal to LAST (round-robin); loser stays pending and wins the next IDLE if still requesting.
REQ-025 A request deasserted before being granted SHALL be dropped with no RAM access and no ACK.
REQ-026 Requests arriving in SERVE/DONE SHALL be ignored until the next IDLE.

Reset
REQ-027 RST=1 SHALL immediately force state IDLE, GNT=0, LAST=1, all outputs zero, regardless of state; an in-flight access is abandoned without ACK.
REQ-028 After RST deasserts, first arbitration SHALL behave as IDLE with LAST=1 (port 0 wins a tie).

Configuration
REQ-029 Macro DFFRAM_ARB_FIXED_PRIO_EN defined: port 0 SHALL always win simultaneous requests; LAST is unused.
REQ-030 Macro DFFRAM_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-024.

Verification
REQ-031 P0 write WE=1111 A=0x010 Di=0xDEADBEEF, then P0 read A=0x010 -> RAM_EN one cycle each, second P0_ACK with P0_Do=0xDEADBEEF.
REQ-032 P1 write WE=0010 Di=0x0000AB00 to word 0x11223344 -> subsequent read returns 0x1122AB44; write ACK returns 0x11223344.
REQ-033 P0 and P1 request together continuously (round-robin build) -> grants alternate 0,1,0,1; ACKs 3 cycles apart; never both ACK.
REQ-034 Same stimulus with DFFRAM_ARB_FIXED_PRIO_EN -> P0 served every access, P1 ACK never while P0_REQ held.
REQ-035 RST pulsed during SERVE of P1 read -> no P1_ACK, all outputs zero within the reset cycle, next tie goes to P0.
REQ-036 P1 REQ pulsed one cycle during P0 SERVE then dropped -> no P1 RAM access, no P1_ACK.
